// File: rtl/seg7_scan_controller_if.sv
// Signal bundle between the value producer / display path and the scan controller.
interface seg7_scan_controller_if;
  logic        enable;
  logic [15:0] value_in;
  logic        value_valid;
  logic [3:0]  dp_mask;
  logic        lz_blank;
  logic [15:0] shadow_value;
  logic [1:0]  mux_control;
  logic [3:0]  anode_n;
  logic        dp_n;
  logic        frame_done;

  // Producer / display side.
  modport master (
    output enable, value_in, value_valid, dp_mask, lz_blank,
    input  shadow_value, mux_control, anode_n, dp_n, frame_done
  );

  // Scan controller side.
  modport slave (
    input  enable, value_in, value_valid, dp_mask, lz_blank,
    output shadow_value, mux_control, anode_n, dp_n, frame_done
  );
endinterface

// File: rtl/seg7_scan_controller.sv
// Four-digit seven-segment scan sequencer with blanking gaps, a frame-stable
// shadow value, leading-zero suppression and registered outputs.
module seg7_scan_controller #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input logic                    clk,
  input logic                    reset,
  seg7_scan_controller_if.slave  bus
);

  localparam int unsigned CntMax = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] TickLast  = CntW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit HasBlank = (BLANK_CYCLES > 0);

  typedef enum logic [1:0] {StIdle, StDrive, StBlank} state_e;

  state_e          state_q, state_d;
  logic [1:0]      digit_q, digit_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     pending_q, pending_d;
  logic            pending_flag_q, pending_flag_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [1:0]      mux_q, mux_d;
  logic [3:0]      anode_q, anode_d;
  logic            dp_q, dp_d;
  logic            frame_done_q, frame_done_d;
  logic            load;
  logic [3:0]      zero_from;
  logic            suppress;

  // State, value and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      digit_q        <= '0;
      cnt_q          <= '0;
      pending_q      <= '0;
      pending_flag_q <= 1'b0;
      shadow_q       <= '0;
      mux_q          <= '0;
      anode_q        <= 4'hF;
      dp_q           <= 1'b1;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      digit_q        <= digit_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      pending_flag_q <= pending_flag_d;
      shadow_q       <= shadow_d;
      mux_q          <= mux_d;
      anode_q        <= anode_d;
      dp_q           <= dp_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // Scan sequencing: phase timing, digit advance and frame-boundary shadow loads.
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    cnt_d        = cnt_q;
    load         = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.enable) begin
          state_d = StDrive;
          digit_d = '0;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      StDrive: begin
        if (!bus.enable) begin
          state_d = StIdle;
          digit_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == TickLast) begin
          cnt_d = '0;
          if (HasBlank) begin
            state_d = StBlank;
          end else begin
            digit_d = digit_q + 2'd1;
            if (digit_q == 2'd3) begin
              frame_done_d = 1'b1;
              load         = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBlank: begin
        if (!bus.enable) begin
          state_d = StIdle;
          digit_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == BlankLast) begin
          cnt_d   = '0;
          state_d = StDrive;
          digit_d = digit_q + 2'd1;
          if (digit_q == 2'd3) begin
            frame_done_d = 1'b1;
            load         = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        digit_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Pending capture and shadow load; a strobe coinciding with a load only
  // refreshes pending, so it shows one frame later.
  always_comb begin
    pending_d      = pending_q;
    pending_flag_d = pending_flag_q;
    shadow_d       = shadow_q;
    if (load && pending_flag_q) begin
      shadow_d       = pending_q;
      pending_flag_d = 1'b0;
    end
    if (bus.value_valid) begin
      pending_d      = bus.value_in;
      pending_flag_d = 1'b1;
    end
  end

  // Next-cycle outputs, decoded from the next state so they line up with it.
  always_comb begin
    zero_from[3] = (shadow_d[15:12] == 4'h0);
    zero_from[2] = zero_from[3] && (shadow_d[11:8] == 4'h0);
    zero_from[1] = zero_from[2] && (shadow_d[7:4] == 4'h0);
    zero_from[0] = zero_from[1] && (shadow_d[3:0] == 4'h0);
    suppress     = bus.lz_blank && (digit_d != 2'd0) && zero_from[digit_d];
    mux_d        = '0;
    anode_d      = 4'hF;
    dp_d         = 1'b1;
    case (state_d)
      StDrive: begin
        mux_d   = digit_d;
        anode_d = suppress ? 4'hF : ~(4'b0001 << digit_d);
        dp_d    = ~bus.dp_mask[digit_d];
      end
      StBlank: begin
        mux_d = digit_d;
      end
      default: ;
    endcase
  end

  assign bus.shadow_value = shadow_q;
  assign bus.mux_control  = mux_q;
  assign bus.anode_n      = anode_q;
  assign bus.dp_n         = dp_q;
  assign bus.frame_done   = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller with TICK_DIV=4, BLANK_CYCLES=2.
module tb_seg7_scan_controller;

  localparam int unsigned TickDiv     = 4;
  localparam int unsigned BlankCycles = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   idx;

  always #5 clk = ~clk;

  seg7_scan_controller_if sif ();

  seg7_scan_controller #(
    .TICK_DIV     (TickDiv),
    .BLANK_CYCLES (BlankCycles)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  // Expected anodes across one full frame starting at the first DRIVE cycle.
  logic [3:0] an_tab [24] = '{
    4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF,
    4'hD, 4'hD, 4'hD, 4'hD, 4'hF, 4'hF,
    4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF,
    4'h7, 4'h7, 4'h7, 4'h7, 4'hF, 4'hF
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (idx %0d)", tag, got, exp, idx);
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    idx++;
  endtask

  task automatic run_to(input int target);
    while (idx < target) step();
  endtask

  task automatic strobe(input logic [15:0] v);
    sif.value_in    = v;
    sif.value_valid = 1'b1;
    step();
    sif.value_valid = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    sif.enable      = 1'b0;
    sif.value_in    = '0;
    sif.value_valid = 1'b0;
    sif.dp_mask     = '0;
    sif.lz_blank    = 1'b0;
    idx             = 0;

    // Reset and idle.
    repeat (3) step();
    check("rst_anode", sif.anode_n, 4'hF);
    check("rst_dp", sif.dp_n, 1'b1);
    check("rst_mux", sif.mux_control, 2'd0);
    check("rst_fd", sif.frame_done, 1'b0);
    check("rst_shadow", sif.shadow_value, 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_outs", {sif.anode_n, sif.dp_n, sif.mux_control, sif.frame_done},
            {4'hF, 1'b1, 2'd0, 1'b0});
    end

    // Scan sequence over one frame plus the next frame's first cycle.
    strobe(16'h1234);
    sif.enable = 1'b1;
    idx = -1;
    step();
    check("scan_shadow0", sif.shadow_value, 16'h1234);
    for (int i = 0; i <= 24; i++) begin
      if (i > 0) step();
      check("scan_anode", sif.anode_n, an_tab[i % 24]);
      check("scan_mux", sif.mux_control, (i % 24) / 6);
      check("scan_fd", sif.frame_done, (i == 24));
      check("scan_dp", sif.dp_n, 1'b1);
    end

    // Tear-free update, plus a strobe coinciding with the load edge.
    run_to(36);
    check("tf_mux2", sif.mux_control, 2'd2);
    strobe(16'hABCD);
    check("tf_hold37", sif.shadow_value, 16'h1234);
    run_to(47);
    check("tf_hold47", sif.shadow_value, 16'h1234);
    strobe(16'h5678);
    check("tf_load48", sif.shadow_value, 16'hABCD);
    check("tf_fd48", sif.frame_done, 1'b1);
    run_to(71);
    check("tf_hold71", sif.shadow_value, 16'hABCD);
    step();
    check("tf_load72", sif.shadow_value, 16'h5678);
    check("tf_fd72", sif.frame_done, 1'b1);

    // Decimal point on digit 2 only.
    sif.dp_mask = 4'b0100;
    run_to(83);
    check("dp_blank1", sif.dp_n, 1'b1);
    for (int i = 84; i < 88; i++) begin
      step();
      check("dp_drive2", sif.dp_n, 1'b0);
      check("dp_mux2", sif.mux_control, 2'd2);
    end
    step();
    check("dp_blank2", sif.dp_n, 1'b1);
    check("dp_blank2_an", sif.anode_n, 4'hF);
    sif.dp_mask = 4'b0000;

    // Leading-zero blanking.
    run_to(90);
    sif.lz_blank = 1'b1;
    strobe(16'h0050);
    run_to(96);
    check("lz50_shadow", sif.shadow_value, 16'h0050);
    check("lz50_d0", sif.anode_n, 4'hE);
    run_to(100);
    strobe(16'h0000);
    run_to(102);
    check("lz50_d1", sif.anode_n, 4'hD);
    run_to(108);
    check("lz50_d2", sif.anode_n, 4'hF);
    check("lz50_mux2", sif.mux_control, 2'd2);
    run_to(114);
    check("lz50_d3", sif.anode_n, 4'hF);
    check("lz50_mux3", sif.mux_control, 2'd3);
    run_to(120);
    check("lz0_shadow", sif.shadow_value, 16'h0000);
    check("lz0_d0", sif.anode_n, 4'hE);
    run_to(126);
    check("lz0_d1", sif.anode_n, 4'hF);
    run_to(132);
    check("lz0_d2", sif.anode_n, 4'hF);
    run_to(138);
    sif.dp_mask = 4'b1000;
    step();
    check("lz0_d3", sif.anode_n, 4'hF);
    check("lz0_dp3", sif.dp_n, 1'b0);
    sif.dp_mask  = 4'b0000;
    sif.lz_blank = 1'b0;

    // Disable during digit 1 DRIVE, then re-enable.
    run_to(150);
    check("dis_pre", sif.anode_n, 4'hD);
    sif.enable = 1'b0;
    step();
    check("dis_outs", {sif.anode_n, sif.dp_n, sif.mux_control, sif.frame_done},
          {4'hF, 1'b1, 2'd0, 1'b0});
    step();
    check("dis_idle", sif.anode_n, 4'hF);
    sif.enable = 1'b1;
    idx = -1;
    strobe(16'h9999);
    check("reen_anode", sif.anode_n, 4'hE);
    check("reen_mux", sif.mux_control, 2'd0);
    check("reen_fd", sif.frame_done, 1'b0);
    check("reen_shadow", sif.shadow_value, 16'h0000);

    // Reset during BLANK drops the pending value.
    run_to(4);
    check("rb_blank", sif.anode_n, 4'hF);
    reset = 1'b1;
    step();
    check("rb_outs", {sif.anode_n, sif.dp_n, sif.mux_control, sif.frame_done},
          {4'hF, 1'b1, 2'd0, 1'b0});
    check("rb_shadow", sif.shadow_value, 16'h0000);
    reset = 1'b0;
    idx = -1;
    step();
    check("rb_restart", sif.anode_n, 4'hE);
    run_to(24);
    check("rb_fd", sif.frame_done, 1'b1);
    check("rb_lost", sif.shadow_value, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
- Time-multiplexed scan sequencer for the 4-digit seven-segment display. It drives the select input of the 4-way nibble multiplexer and the active-low anodes.
- Holds a tear-free shadow copy of the 16-bit display value, updated only at frame boundaries.
- Inserts an all-off blanking gap between digits to suppress ghosting, and optionally blanks leading zeros.
- Sits between the mouse-status/position logic (value producer) and the nibble mux plus segment decoder.

Parameters:
- TICK_DIV, 100000, clock cycles each digit's anode is driven (1 kHz per digit at 100 MHz); legal range >= 1.
- BLANK_CYCLES, 1000, all-anodes-off cycles between consecutive digits; 0 means no gap.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  scan enable; low forces idle with the display dark.
- VALUE_IN  in  16  display value; [3:0]=digit 0 (rightmost) … [15:12]=digit 3.
- VALUE_VALID  in  1  one-cycle strobe that captures VALUE_IN into the pending register.
- DP_MASK  in  4  decimal-point enables per digit, bit n = digit n; sampled live.
- LZ_BLANK  in  1  leading-zero blanking enable, sampled live.
- SHADOW_VALUE  out  16  frame-stable value; feeds mux IN0..IN3 as nibbles 0..3.
- MUX_CONTROL  out  2  digit select to the mux CONTROL input.
- ANODE_N  out  4  active-low anodes, bit n = digit n.
- DP_N  out  1  active-low decimal point for the current digit.
- FRAME_DONE  out  1  one-cycle pulse at the end of each complete 4-digit frame.

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high on RESET. All outputs are registered.
- Reset values:
  - state=IDLE; MUX_CONTROL=0; ANODE_N=4'hF; DP_N=1; FRAME_DONE=0.
  - SHADOW_VALUE=0; pending=0; pending_flag=0; cycle counter=0.
- Pending capture:
  - VALUE_VALID=1 writes VALUE_IN to pending and sets pending_flag, in any state.
  - A later strobe overwrites pending (last write wins).
- States:
  - IDLE: ANODE_N=F, DP_N=1, MUX_CONTROL=0. When ENABLE=1, the next edge enters DRIVE for digit 0 and performs a shadow load.
  - DRIVE: MUX_CONTROL=digit. ANODE_N has only the digit bit low, unless that digit is suppressed (see leading-zero rule). DP_N=~DP_MASK[digit]. Lasts exactly TICK_DIV cycles, then goes to BLANK (or straight to next-digit DRIVE if BLANK_CYCLES=0).
  - BLANK: ANODE_N=F, DP_N=1, MUX_CONTROL holds the current digit. Lasts exactly BLANK_CYCLES cycles. Then digit increments modulo 4 and the block enters DRIVE.
- Frame boundary (digit 3 → 0):
  - FRAME_DONE=1 for exactly one cycle, coincident with the first DRIVE cycle of digit 0.
  - Shadow load on the same edge.
- Shadow load:
  - If pending_flag=1: SHADOW_VALUE←pending and pending_flag←0. Otherwise SHADOW_VALUE is unchanged.
  - A VALUE_VALID in the same cycle as a load updates pending only; that value is shown in the next frame.
- Leading-zero rule (LZ_BLANK=1): digit n∈{3,2,1} is suppressed (anode stays high, DP_N still follows DP_MASK) when SHADOW_VALUE nibbles n..3 are all zero. Digit 0 is never suppressed.
- ENABLE=0 in DRIVE or BLANK: the next edge goes to IDLE. Counter and digit are cleared, no FRAME_DONE, pending is retained.
- RESET mid-frame: the next edge returns all state to reset values. A pending value is lost.
- Counter width: ceil(log2(max(TICK_DIV,BLANK_CYCLES)+1)) bits. The counter never wraps within a phase.
- Frame period: 4×(TICK_DIV+BLANK_CYCLES) cycles.

Test Plan:
- Bench parameters: TICK_DIV=4, BLANK_CYCLES=2, frame = 24 cycles.
- Reset/idle: RESET=1 for 3 cycles, then ENABLE=0 for 10 cycles → ANODE_N=F, DP_N=1, MUX_CONTROL=0, FRAME_DONE=0 throughout.
- Scan sequence: VALUE_VALID with VALUE_IN=16'h1234, then ENABLE=1 →
  - SHADOW_VALUE=1234 from the first DRIVE.
  - ANODE_N pattern E×4, F×2, D×4, F×2, B×4, F×2, 7×4, F×2.
  - MUX_CONTROL 0,1,2,3; FRAME_DONE on cycle 25 only (first DRIVE of the next frame).
- Tear-free update: strobe VALUE_IN=16'hABCD mid-frame at digit 2 → SHADOW_VALUE stays 1234 until the FRAME_DONE edge, then becomes ABCD. A strobe coinciding with that edge appears only one frame later.
- Leading zeros: LZ_BLANK=1, value 16'h0050 → digits 3 and 2 keep anode high, digits 1 and 0 are driven. With value 16'h0000, only digit 0 is driven.
- Decimal point: DP_MASK=4'b0100 → DP_N=0 only during digit 2 DRIVE cycles, 1 elsewhere, including during BLANK.
- Disable/reset mid-frame: drop ENABLE during digit 1 DRIVE → next cycle ANODE_N=F. Re-enabling restarts at digit 0. RESET during BLANK → next cycle all reset values, SHADOW_VALUE=0.
